// File: rtl/bcrypt_pkg.sv
// bcrypt_pkg: shared constants and core FSM encoding for the bcrypt core scheduler
package bcrypt_pkg;
    localparam int NUM_CORES_DEF = 4;
    localparam int IDX_W_DEF = 2;
    localparam int CNT_W = 32;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE_WAIT,
        ST_CLEAR
    } core_state_e;
endpackage

// File: rtl/bcrypt_rr_arb.sv
// bcrypt_rr_arb: round-robin pick of the first set request after the pointer index
module bcrypt_rr_arb #(
    parameter int N = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);
    function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] p, input int i);
        return IDX_W'((int'(p) + i) % N);
    endfunction

    // Scan from farthest to nearest so the last hit is the closest one after ptr_i
    always_comb begin
        grant_o = '0;
        for (int i = N; i >= 1; i--) begin
            if (req_i[rot(ptr_i, i)]) grant_o = rot(ptr_i, i);
        end
    end

    assign any_o = |req_i;
endmodule

// File: rtl/bcrypt_core_sched.sv
// bcrypt_core_sched: dispatches host jobs to idle bcrypt cores round-robin,
// times each run and reports finished cores back to the host one at a time.
module bcrypt_core_sched
    import bcrypt_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_req,
    output logic                 host_ack,
    output logic [IDX_W-1:0]     host_core,
    output logic [NUM_CORES-1:0] core_start,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 result_valid,
    output logic [IDX_W-1:0]     result_core,
    output logic [CNT_W-1:0]     result_cycles,
    input  logic                 result_ready,
    output logic [NUM_CORES-1:0] busy
);
    core_state_e          state_q [NUM_CORES];
    core_state_e          state_d [NUM_CORES];
    logic [CNT_W-1:0]     cnt_q [NUM_CORES];
    logic [CNT_W-1:0]     cnt_d [NUM_CORES];
    logic [IDX_W-1:0]     disp_ptr_q, disp_ptr_d, res_ptr_q, res_ptr_d, res_sel_q, res_sel_d;
    logic                 res_valid_q, res_valid_d;
    logic [NUM_CORES-1:0] idle, waiting;
    logic [IDX_W-1:0]     disp_idx, res_idx;
    logic                 disp_any, res_any, res_xfer;

    bcrypt_rr_arb #(.N(NUM_CORES), .IDX_W(IDX_W)) u_disp_arb (
        .req_i(idle), .ptr_i(disp_ptr_q), .grant_o(disp_idx), .any_o(disp_any)
    );

    bcrypt_rr_arb #(.N(NUM_CORES), .IDX_W(IDX_W)) u_res_arb (
        .req_i(waiting), .ptr_i(res_ptr_q), .grant_o(res_idx), .any_o(res_any)
    );

    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            idle[k] = state_q[k] == ST_IDLE;
            waiting[k] = state_q[k] == ST_DONE_WAIT;
            core_start[k] = state_q[k] == ST_RUN || waiting[k];
            busy[k] = !idle[k];
        end
    end

    // Reset leaves every core IDLE, so the ack must be masked explicitly
    assign host_ack = host_req && disp_any && !rst;
    assign host_core = disp_idx;
    assign res_xfer = res_valid_q && result_ready;
    assign result_valid = res_valid_q;
    assign result_core = res_sel_q;
    assign result_cycles = cnt_q[res_sel_q];

    always_comb begin
        disp_ptr_d = host_ack ? disp_idx : disp_ptr_q;
        res_ptr_d = res_xfer ? res_sel_q : res_ptr_q;
        res_valid_d = res_xfer ? 1'b0 : (res_valid_q || res_any);
        res_sel_d = (!res_valid_q && res_any) ? res_idx : res_sel_q;
        for (int k = 0; k < NUM_CORES; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k] = cnt_q[k];
            case (state_q[k])
                ST_IDLE: begin
                    if (host_ack && disp_idx == IDX_W'(k)) begin
                        state_d[k] = ST_RUN;
                        cnt_d[k] = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d[k] = (&cnt_q[k]) ? cnt_q[k] : cnt_q[k] + CNT_W'(1);
                    // A zero count marks the first RUN cycle, where done is still stale
                    if (core_done[k] && cnt_q[k] != '0) state_d[k] = ST_DONE_WAIT;
                end
                ST_DONE_WAIT: begin
                    if (res_xfer && res_sel_q == IDX_W'(k)) state_d[k] = ST_CLEAR;
                end
                default: state_d[k] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k] <= '0;
            end
            disp_ptr_q <= IDX_W'(NUM_CORES - 1);
            res_ptr_q <= IDX_W'(NUM_CORES - 1);
            res_sel_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            disp_ptr_q <= disp_ptr_d;
            res_ptr_q <= res_ptr_d;
            res_sel_q <= res_sel_d;
            res_valid_q <= res_valid_d;
        end
    end
endmodule

// File: tb/tb_bcrypt_core_sched.sv
// tb_bcrypt_core_sched: directed corner sequences, a dispatch-order table and
// randomized traffic checked against a behavioural scheduler model.
module tb_bcrypt_core_sched;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_req = 1'b0;
    logic          host_ack;
    logic [1:0]    host_core;
    logic [NC-1:0] core_start;
    logic [NC-1:0] core_done = '0;
    logic          result_valid;
    logic [1:0]    result_core;
    logic [31:0]   result_cycles;
    logic          result_ready = 1'b0;
    logic [NC-1:0] busy;

    int checks = 0;
    int errors = 0;

    bcrypt_core_sched #(.NUM_CORES(NC), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .host_req(host_req), .host_ack(host_ack),
        .host_core(host_core), .core_start(core_start), .core_done(core_done),
        .result_valid(result_valid), .result_core(result_core),
        .result_cycles(result_cycles), .result_ready(result_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        host_req = 1'b0;
        core_done = '0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic dispatch(input logic [1:0] exp_core);
        @(negedge clk);
        host_req = 1'b1;
        #1;
        chk("disp_ack", host_ack, 1);
        chk("disp_core", host_core, exp_core);
        @(posedge clk);
        #1 host_req = 1'b0;
    endtask

    task automatic pulse_done(input logic [NC-1:0] d);
        core_done = d;
        @(posedge clk);
        #1 core_done = '0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!result_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", result_valid, 1);
    endtask

    task automatic xfer();
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
    endtask

    // Behavioural model: per-core activity flags, run lengths and two pointers
    bit              m_run [NC];
    bit              m_fin [NC];
    bit              m_clr [NC];
    longint unsigned m_cyc [NC];
    int              m_dptr, m_rptr, m_rsel;
    bit              m_rvalid;

    function automatic int rr_pick(input bit cand [NC], input int ptr);
        for (int i = 1; i <= NC; i++) if (cand[(ptr + i) % NC]) return (ptr + i) % NC;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_run[k] = 0; m_fin[k] = 0; m_clr[k] = 0; m_cyc[k] = 0;
        end
        m_dptr = NC - 1; m_rptr = NC - 1; m_rsel = 0; m_rvalid = 0;
    endtask

    task automatic model_check();
        bit idle [NC];
        int p;
        bit e_ack;
        logic [NC-1:0] e_start, e_busy;
        logic [45:0] exp_v, act_v;
        for (int k = 0; k < NC; k++) begin
            idle[k] = !(m_run[k] || m_fin[k] || m_clr[k]);
            e_start[k] = m_run[k] || m_fin[k];
            e_busy[k] = !idle[k];
        end
        p = rr_pick(idle, m_dptr);
        e_ack = host_req && p >= 0;
        exp_v = {e_ack, e_ack ? 2'(p) : 2'd0, e_start, e_busy, m_rvalid,
                 m_rvalid ? {2'(m_rsel), 32'(m_cyc[m_rsel])} : 34'd0};
        act_v = {host_ack, host_ack ? host_core : 2'd0, core_start, busy, result_valid,
                 result_valid ? {result_core, result_cycles} : 34'd0};
        chk("rand_cycle", act_v, exp_v);
    endtask

    task automatic model_step(input bit req, input logic [NC-1:0] done, input bit ready);
        bit idle [NC];
        int d, r;
        bit rx;
        for (int k = 0; k < NC; k++) idle[k] = !(m_run[k] || m_fin[k] || m_clr[k]);
        d = req ? rr_pick(idle, m_dptr) : -1;
        r = rr_pick(m_fin, m_rptr);
        rx = m_rvalid && ready;
        for (int k = 0; k < NC; k++) begin
            if (m_clr[k]) m_clr[k] = 0;
            else if (rx && m_rsel == k) begin
                m_fin[k] = 0;
                m_clr[k] = 1;
            end else if (m_run[k]) begin
                if (done[k] && m_cyc[k] > 0) begin
                    m_run[k] = 0;
                    m_fin[k] = 1;
                end
                if (m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k]++;
            end
        end
        if (d >= 0) begin
            m_run[d] = 1;
            m_cyc[d] = 0;
            m_dptr = d;
        end
        if (rx) begin
            m_rptr = m_rsel;
            m_rvalid = 0;
        end else if (!m_rvalid && r >= 0) begin
            m_rsel = r;
            m_rvalid = 1;
        end
    endtask

    typedef struct {
        bit         req;
        bit         ack;
        logic [1:0] core;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 2'd0};
        tbl[1] = '{1'b1, 1'b1, 2'd1};
        tbl[2] = '{1'b1, 1'b1, 2'd2};
        tbl[3] = '{1'b1, 1'b1, 2'd3};
        tbl[4] = '{1'b1, 1'b0, 2'd0};
        tbl[5] = '{1'b1, 1'b0, 2'd0};

        host_req = 1'b1;
        #3;
        chk("rst_ack", host_ack, 0);
        chk("rst_outs", {core_start, busy, result_valid, result_core, result_cycles}, 0);
        do_reset();

        // Back-to-back dispatch order, then saturation with every core busy
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            host_req = tbl[i].req;
            #1;
            chk($sformatf("order_ack[%0d]", i), host_ack, tbl[i].ack);
            if (tbl[i].ack) chk($sformatf("order_core[%0d]", i), host_core, tbl[i].core);
        end
        @(posedge clk);
        #1 host_req = 1'b0;

        // Cycle count of 100 on core 2, then the one-cycle clear
        do_reset();
        dispatch(0);
        dispatch(1);
        dispatch(2);
        repeat (99) @(posedge clk);
        #1 pulse_done(4'b0100);
        wait_valid();
        chk("lat_core", result_core, 2);
        chk("lat_cycles", result_cycles, 100);
        chk("lat_start_dw", core_start[2], 1);
        xfer();
        @(negedge clk);
        chk("clr_start", core_start[2], 0);
        chk("clr_busy", busy[2], 1);
        chk("clr_valid", result_valid, 0);
        @(negedge clk);
        chk("idle_busy", busy[2], 0);

        // Two cores finish together; the report must hold stable until taken
        do_reset();
        for (int i = 0; i < NC; i++) dispatch(2'(i));
        repeat (3) @(posedge clk);
        #1 pulse_done(4'b1010);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_core[%0d]", i), result_core, 1);
            chk($sformatf("hold_cycles[%0d]", i), result_cycles, 6);
            @(negedge clk);
        end
        xfer();
        @(negedge clk);
        chk("gap_valid", result_valid, 0);
        wait_valid();
        chk("fair_core", result_core, 3);
        chk("fair_cycles", result_cycles, 4);
        xfer();

        // Result transfer for core 0 and dispatch to core 1 in the same cycle
        do_reset();
        for (int i = 0; i < NC; i++) dispatch(2'(i));
        pulse_done(4'b0010);
        wait_valid();
        chk("sim_first", result_core, 1);
        xfer();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 pulse_done(4'b0001);
        wait_valid();
        chk("sim_res_core", result_core, 0);
        host_req = 1'b1;
        result_ready = 1'b1;
        #1;
        chk("sim_ack", host_ack, 1);
        chk("sim_core", host_core, 1);
        @(posedge clk);
        #1 result_ready = 1'b0;
        @(negedge clk);
        #1 chk("sim_clear_block", host_ack, 0);
        @(negedge clk);
        #1;
        chk("sim_reuse_ack", host_ack, 1);
        chk("sim_reuse_core", host_core, 0);
        @(posedge clk);
        #1 host_req = 1'b0;

        // Asynchronous reset with three cores running
        do_reset();
        dispatch(0);
        dispatch(1);
        dispatch(2);
        @(negedge clk);
        chk("pre_rst_start", core_start, 4'b0111);
        #2;
        rst = 1'b1;
        host_req = 1'b1;
        #1;
        chk("async_start", core_start, 0);
        chk("async_busy", busy, 0);
        chk("async_ack", host_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ack", host_ack, 1);
        chk("post_rst_core", host_core, 0);
        @(posedge clk);
        #1 host_req = 1'b0;

        // Stale done on core 1 while idle and during its first RUN cycle
        do_reset();
        core_done = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stale_idle[%0d]", i), {result_valid, busy}, 0);
        end
        dispatch(0);
        dispatch(1);
        @(negedge clk);
        chk("stale_run1_valid", result_valid, 0);
        chk("stale_run1_start", core_start[1], 1);
        @(negedge clk);
        chk("stale_run2_valid", result_valid, 0);
        wait_valid();
        chk("stale_core", result_core, 1);
        chk("stale_cycles", result_cycles, 2);
        core_done = '0;
        xfer();

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            host_req = 1'($urandom_range(0, 1));
            result_ready = 1'($urandom_range(0, 1));
            for (int k = 0; k < NC; k++) core_done[k] = ($urandom_range(0, 5) == 0);
            #1;
            model_check();
            model_step(host_req, core_done, result_ready);
            @(negedge clk);
        end
        host_req = 1'b0;
        result_ready = 1'b0;
        core_done = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
